// File: rtl/mips_data_responder.sv
// Data-bus responder for the single-cycle MIPS core: word RAM plus a
// four-word I/O window (cycle counter, store-log FIFO, sticky status flags).
module mips_data_responder #(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LOG_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_FFF0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  adr,
    input  logic [31:0]                  write_data,
    input  logic                         mem_read,
    input  logic                         mem_write,
    output logic [31:0]                  read_data,
    output logic                         log_valid,
    output logic [31:0]                  log_data,
    input  logic                         log_pop,
    output logic [$clog2(LOG_DEPTH):0]   log_count
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam int unsigned PW        = $clog2(LOG_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    localparam logic [1:0] OFS_CNT  = 2'd0;
    localparam logic [1:0] OFS_LOG  = 2'd1;
    localparam logic [1:0] OFS_STAT = 2'd2;

    // Storage
    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   log_buf [LOG_DEPTH];

    // State
    logic [31:0]   cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          ovf;
    logic          unmapped;
    logic          misalign;

    // Decode
    logic          aligned;
    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    offset;
    logic          access;
    logic          wr_ok;
    logic [AW-1:0] ram_idx;

    // Derived controls
    logic          misalign_set;
    logic          unmapped_set;
    logic          ovf_set;
    logic          cnt_clr;
    logic          log_push;
    logic          stat_clr;
    logic          ram_we;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_ok;
    logic          push_ok;
    logic [31:0]   stat_word;

    // Address decode and access qualification
    always_comb begin
        aligned      = (adr[1:0] == 2'b00);
        ram_hit      = (adr < RAM_BYTES);
        mmio_hit     = (adr[31:4] == MMIO_BASE[31:4]);
        offset       = adr[3:2];
        access       = mem_read | mem_write;
        ram_idx      = adr[AW+1:2];
        wr_ok        = mem_write & aligned;

        misalign_set = access & ~aligned;
        unmapped_set = access & aligned & ~ram_hit & ~mmio_hit;

        cnt_clr      = wr_ok & ~ram_hit & mmio_hit & (offset == OFS_CNT);
        log_push     = wr_ok & ~ram_hit & mmio_hit & (offset == OFS_LOG);
        stat_clr     = wr_ok & ~ram_hit & mmio_hit & (offset == OFS_STAT) & write_data[0];
        ram_we       = wr_ok & ram_hit & ~rst;

        fifo_full    = (count == CW'(LOG_DEPTH));
        fifo_empty   = (count == '0);
        pop_ok       = log_pop & ~fifo_empty;
        // A push into a full FIFO survives only when a pop frees a slot at the same edge
        push_ok      = log_push & (~fifo_full | pop_ok);
        ovf_set      = log_push & fifo_full & ~pop_ok;
    end

    // Status word as seen by a STAT read
    always_comb begin
        stat_word = {ovf, unmapped, misalign, 13'b0, 16'(count)};
    end

    // Zero-latency load mux; suppressed loads and unmapped loads read as 0
    always_comb begin
        read_data = '0;
        if (mem_read && aligned) begin
            if (ram_hit) begin
                read_data = mem[ram_idx];
            end else if (mmio_hit) begin
                case (offset)
                    OFS_CNT:  read_data = cnt;
                    OFS_STAT: read_data = stat_word;
                    default:  read_data = '0;
                endcase
            end
        end
    end

    // FIFO head presentation
    always_comb begin
        log_valid = ~fifo_empty;
        log_count = count;
        log_data  = fifo_empty ? 32'd0 : log_buf[head];
    end

    // RAM store port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= write_data;
        end
    end

    // FIFO entry storage; only occupancy is cleared by reset
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            log_buf[tail] <= write_data;
        end
    end

    // Free-running cycle counter, cleared by a CNT store
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop_ok) begin
                head <= head + PW'(1);
            end
            if (push_ok) begin
                tail <= tail + PW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky error flags; a new event outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            unmapped <= 1'b0;
            misalign <= 1'b0;
        end else begin
            ovf      <= ovf_set      | (ovf      & ~stat_clr);
            unmapped <= unmapped_set | (unmapped & ~stat_clr);
            misalign <= misalign_set | (misalign & ~stat_clr);
        end
    end

endmodule

// File: tb/tb_mips_data_responder.sv
// Scoreboarded bench for mips_data_responder with a queue-based reference model.
module tb_mips_data_responder;

    localparam logic [31:0] BASE  = 32'h0000_FFF0;
    localparam logic [31:0] A_CNT = BASE;
    localparam logic [31:0] A_LOG = BASE + 32'd4;
    localparam logic [31:0] A_ST  = BASE + 32'd8;
    localparam logic [31:0] A_RSV = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        log_valid;
    logic [31:0] log_data;
    logic        log_pop;
    logic [3:0]  log_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] rdata;
        logic        valid;
        logic [31:0] data;
        logic [3:0]  count;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] ram_m [256];
    logic [31:0] fifo_m[$];
    logic [31:0] cnt_m;
    bit          ovf_m, unm_m, mis_m;

    mips_data_responder dut (
        .clk        (clk),
        .rst        (rst),
        .adr        (adr),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .log_valid  (log_valid),
        .log_data   (log_data),
        .log_pop    (log_pop),
        .log_count  (log_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd16);
    endfunction

    function automatic logic [31:0] m_read(input bit rd, input logic [31:0] a);
        if (!rd || a[1:0] != 2'b00) return 32'd0;
        if (a < 32'd1024) return ram_m[a[9:2]];
        if (a == A_CNT) return cnt_m;
        if (a == A_ST)  return {ovf_m, unm_m, mis_m, 13'b0, 16'(fifo_m.size())};
        return 32'd0;
    endfunction

    // Apply one edge of the specification's rules to the model
    task automatic m_step(input bit r, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd, input bit lp);
        bit acc, al, ram, wok, clr, push, pop, full;
        if (r) begin
            cnt_m = 0;
            fifo_m.delete();
            ovf_m = 0; unm_m = 0; mis_m = 0;
            return;
        end
        acc  = rd || wr;
        al   = (a[1:0] == 2'b00);
        ram  = (a < 32'd1024);
        wok  = wr && al;
        clr  = wok && (a == A_ST) && wd[0];
        push = wok && (a == A_LOG);
        pop  = lp && (fifo_m.size() > 0);
        full = (fifo_m.size() == 8);
        cnt_m = (wok && a == A_CNT) ? 32'd0 : cnt_m + 32'd1;
        if (pop) void'(fifo_m.pop_front());
        if (push) begin
            if (full && !pop) ovf_m = 1;
            else fifo_m.push_back(wd);
        end else if (clr) ovf_m = 0;
        if (push && full && !pop) ovf_m = 1;
        else if (clr) ovf_m = 0;
        if (acc && !al) mis_m = 1;
        else if (clr) mis_m = 0;
        if (acc && al && !ram && !in_mmio(a)) unm_m = 1;
        else if (clr) unm_m = 0;
        if (wok && ram) ram_m[a[9:2]] = wd;
    endtask

    // Drive one cycle: record expected outputs, then advance the model at the edge
    task automatic cyc(input bit r, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] wd, input bit lp);
        exp_t e;
        rst = r; mem_read = rd; mem_write = wr; adr = a; write_data = wd; log_pop = lp;
        e.adr   = a;
        e.rdata = m_read(rd, a);
        e.valid = (fifo_m.size() > 0);
        e.data  = (fifo_m.size() > 0) ? fifo_m[0] : 32'd0;
        e.count = 4'(fifo_m.size());
        exp_q.push_back(e);
        @(posedge clk);
        m_step(r, rd, wr, a, wd, lp);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0, 32'd0, 0);
    endtask

    // Monitor: compare presented outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("read_data@%h", e.adr), read_data, e.rdata);
            check("log_valid", 32'(log_valid), 32'(e.valid));
            check("log_count", 32'(log_count), 32'(e.count));
            check("log_data",  log_data, e.data);
        end
    end

    function automatic logic [31:0] rand_adr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 32'($urandom_range(0, 255)) * 32'd4;
            4:          a = A_CNT;
            5, 6:       a = A_LOG;
            7:          a = ($urandom_range(0, 1) == 0) ? A_ST : A_RSV;
            8:          a = ($urandom_range(0, 1) == 0) ? 32'h0000_8000 : 32'h0000_0400 + 32'($urandom_range(0, 63)) * 32'd4;
            default:    a = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        endcase
        return a;
    endfunction

    initial begin
        logic [31:0] a, wd;
        bit rd, wr;
        rst = 1; adr = 0; write_data = 0; mem_read = 0; mem_write = 0; log_pop = 0;
        cnt_m = 0; ovf_m = 0; unm_m = 0; mis_m = 0;
        @(posedge clk); #1;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, A_ST, 0, 0);

        // Initialise every RAM word so later loads are defined
        for (int i = 0; i < 256; i++) cyc(0, 0, 1, 32'(i) * 32'd4, $urandom, 0);

        // RAM store/load, and no-load reads as 0
        cyc(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0);
        cyc(0, 1, 0, 32'h10, 0, 0);
        cyc(0, 0, 0, 32'h14, 0, 0);
        // Load and store to the same word in one cycle
        cyc(0, 1, 1, 32'h20, 32'h1234_5678, 0);
        cyc(0, 1, 0, 32'h20, 0, 0);

        // Counter after reset, CNT clear
        cyc(1, 0, 0, 0, 0, 0);
        idle(5);
        cyc(0, 1, 0, A_CNT, 0, 0);
        cyc(0, 0, 1, A_CNT, 0, 0);
        cyc(0, 1, 0, A_CNT, 0, 0);
        cyc(0, 1, 0, A_CNT, 0, 0);

        // FIFO fill, overflow, drain
        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, A_LOG, 32'(i), 0);
        cyc(0, 1, 0, A_LOG, 0, 0);
        cyc(0, 0, 1, A_LOG, 32'd9, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, A_ST, 32'd1, 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 8; i++) cyc(0, 0, 1, A_LOG, 32'(i), 0);
        cyc(0, 0, 1, A_LOG, 32'hAA, 1);
        cyc(0, 1, 0, A_ST, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);
        // Empty FIFO with simultaneous push and pop
        cyc(0, 0, 1, A_LOG, 32'h55, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Error flags
        cyc(0, 1, 0, 32'h11, 0, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        cyc(0, 0, 1, 32'h8000, 32'h77, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        cyc(0, 0, 1, A_ST, 32'd0, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        cyc(0, 0, 1, A_ST, 32'd1, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        cyc(0, 0, 1, A_RSV, 32'hFFFF_FFFF, 0);
        cyc(0, 1, 0, A_RSV, 0, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        cyc(0, 0, 1, 32'h12, 32'hBAD, 0);
        cyc(0, 1, 0, 32'h10, 0, 0);

        // Mid-operation reset
        for (int i = 1; i <= 3; i++) cyc(0, 0, 1, A_LOG, 32'(i * 16), 0);
        cyc(0, 0, 1, A_CNT, 0, 0);
        idle(37);
        cyc(0, 1, 0, A_CNT, 0, 0);
        cyc(1, 0, 1, 32'h10, 32'h0BAD_0BAD, 0);
        cyc(0, 1, 0, A_CNT, 0, 0);
        cyc(0, 1, 0, A_ST, 0, 0);
        cyc(0, 1, 0, 32'h10, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a  = rand_adr();
            wd = $urandom;
            if (a == A_ST && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            cyc(($urandom_range(0, 299) == 0), rd, wr, a, wd, ($urandom_range(0, 2) == 0));
        end

        idle(1);
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
